ttl_updown_counter_chain: RTL
=============================

Name: ttl_updown_counter_chain

Overview:
Parametrised synchronous up/down counter built from cascaded 4-bit stages, with per-stage modulo (binary or decade). It generalises the single-nibble 74161-style counter to the 74160/74162/74168/74169 family. Carry between stages is internal and has no ripple-timing hazards. It serves the arcade boards as the scroll, timer and sprite-address counters wherever chained 7416x parts appear on the schematics.

Parameters:
STAGES, 2, number of cascaded 4-bit stages; total width = 4*STAGES
MODULO, 16, count modulus per stage (2..16); 10 = BCD/decade, 16 = binary
DELAY_RISE, 0, simulation-only rise delay on Q/RCO outputs
DELAY_FALL, 0, simulation-only fall delay on Q/RCO outputs

Ports:
Clk  input  1  counter clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high master reset
Clear_bar  input  1  synchronous clear, active-low
Load_bar  input  1  synchronous parallel load, active-low
ENP  input  1  count enable (parallel), active-high
ENT  input  1  count enable (trickle), active-high; also gates RCO
Up_Dn  input  1  direction: 1 = up, 0 = down
D  input  4*STAGES  parallel load data; stage i = D[4i+3:4i]
Q  output  4*STAGES  counter value; stage i = Q[4i+3:4i]
Stage_TC  output  STAGES  per-stage terminal-count flags (ungated by ENT)
RCO  output  1  ripple carry out for external cascading

Behaviour:
- Reset=1: Q = 0 immediately, independent of Clk. Stage_TC and RCO follow Q combinationally: up mode gives TC=0 (MODULO>1); down mode gives TC=1 and RCO=ENT.
- Reset deasserted mid-operation: the first count occurs at the first Clk edge with Reset=0. There is no extra settling cycle.
- Synchronous priority at each rising Clk edge: Clear_bar=0 > Load_bar=0 > count > hold.
- Clear_bar=0: all stages become 0.
- Load_bar=0 (Clear_bar=1): Q <= D exactly, including nibble values >= MODULO. ENP and ENT are ignored.
- Count condition: Clear_bar=1, Load_bar=1, ENP=1, ENT=1. Otherwise Q holds.
- Per-stage terminal:
  - up: TC_i = (Q_i >= MODULO-1)
  - down: TC_i = (Q_i == 0)
- Stage enable: stage 0 steps whenever the count condition holds. Stage i steps only when the count condition holds and TC_j = 1 for every j < i. All stages update on the same edge.
- Stage step, up: Q_i >= MODULO-1 -> 0; otherwise Q_i + 1. An illegal loaded value therefore wraps to 0 and carries.
- Stage step, down: Q_i == 0 -> MODULO-1; otherwise Q_i - 1. Illegal values decrement normally.
- Stage_TC[i] = TC_i. Combinational from Q and Up_Dn; does not depend on ENP or ENT.
- RCO = ENT & (AND of all TC_i). Combinational; does not depend on ENP.
- Up_Dn change: Stage_TC and RCO update immediately. Count direction takes effect at the next edge.
- Full wrap: up from all stages = MODULO-1 gives all 0. Down from all 0 gives all MODULO-1. In both cases RCO=1 (if ENT) in the cycle before the wrap.
- Q and RCO carry the #(DELAY_RISE, DELAY_FALL) assignment delays. Internal logic has zero delay.

Decomposition:
- Shared package/header holds:
  - STAGE_W = 4
  - direction encoding (DIR_UP = 1, DIR_DOWN = 0)
  - the MODULO legality check (2..16), raising an elaboration error if violated
- Sub-module ttl_counter_stage: one 4-bit stage with ports for Clk, Reset, clear, load, step-enable, direction, D nibble, Q nibble and TC, instantiated STAGES times by a generate loop.
- The top level owns the carry-enable AND chain, RCO, and the output delays.

Test Plan:
- STAGES=2, MODULO=10, load 0x97, up, ENP=ENT=1. Expect Q 0x97 -> 0x98 -> 0x99 (RCO=1) -> 0x00 (RCO=0) -> 0x01.
- Same config, load 0x01, down. Expect Q 0x01 -> 0x00 (RCO=1) -> 0x99 -> 0x98. Toggle Up_Dn at Q=0x98: RCO stays 0, and the next edge gives 0x99.
- STAGES=3, MODULO=16, load 0xFFE, up. Expect 0xFFF (RCO=1, Stage_TC=3'b111) -> 0x000. With ENT=0 at 0xFFF: RCO=0, Q holds, Stage_TC still 3'b111.
- MODULO=10, load illegal 0x0C, up. Expect 0x10 next edge. Load 0x0C, down: expect 0x0B.
- Priority: Clear_bar=0 and Load_bar=0 with D=0x55 gives Q=0x00. Load_bar=0 with ENP=0 gives Q=0x55. ENP=0, ENT=1 gives Q holding, with RCO still valid at the terminal value.
- Async reset: assert Reset mid-count between edges. Q=0 before the next Clk edge. Release Reset just before an edge with the count enabled: Q=0x01 after that edge.

Source files
------------

// File: rtl/ttl_updown_counter_chain_pkg.sv
// Shared definitions for the cascaded 7416x-style up/down counter.
package ttl_updown_counter_chain_pkg;

    // Width of one counter stage (one TTL part)
    localparam int STAGE_W = 4;

    // Direction encoding carried on Up_Dn
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A stage modulus must fit in one nibble and be able to count at all
    function automatic bit modulo_legal(input int modulo);
        return (modulo >= 2) && (modulo <= 16);
    endfunction

endpackage

// File: rtl/ttl_updown_counter_chain_if.sv
// Control, data and status bundle of the counter chain.
interface ttl_updown_counter_chain_if #(
    parameter int STAGES = 2
);
    import ttl_updown_counter_chain_pkg::*;

    logic                       Clear_bar;
    logic                       Load_bar;
    logic                       ENP;
    logic                       ENT;
    logic                       Up_Dn;
    logic [STAGE_W*STAGES-1:0]  D;
    logic [STAGE_W*STAGES-1:0]  Q;
    logic [STAGES-1:0]          Stage_TC;
    logic                       RCO;

    // Board side: drives controls and load data, observes the count
    modport master (
        output Clear_bar, Load_bar, ENP, ENT, Up_Dn, D,
        input  Q, Stage_TC, RCO
    );

    // Counter side
    modport slave (
        input  Clear_bar, Load_bar, ENP, ENT, Up_Dn, D,
        output Q, Stage_TC, RCO
    );

endinterface

// File: rtl/ttl_updown_counter_chain_stage.sv
// One 4-bit counter stage with selectable modulus and direction.
module ttl_counter_stage
    import ttl_updown_counter_chain_pkg::*;
#(
    parameter int MODULO = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clear,
    input  logic               load,
    input  logic               step_en,
    input  logic               dir,
    input  logic [STAGE_W-1:0] d,
    output logic [STAGE_W-1:0] q,
    output logic               tc
);

    localparam logic [STAGE_W-1:0] TOP_VAL = STAGE_W'(MODULO - 1);

    // Terminal count: at or above the top value going up (so illegal
    // loaded values also carry), at zero going down
    always_comb begin
        tc = 1'b0;
        if (dir == DIR_UP) begin
            tc = (q >= TOP_VAL);
        end else begin
            tc = (q == '0);
        end
    end

    // Nibble register: clear beats load beats step; terminal values wrap
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (step_en) begin
            if (dir == DIR_UP) begin
                q <= tc ? '0 : q + 1'b1;
            end else begin
                q <= tc ? TOP_VAL : q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttl_updown_counter_chain.sv
// Synchronous up/down counter chain of STAGES nibbles, binary or decade.
module ttl_updown_counter_chain
    import ttl_updown_counter_chain_pkg::*;
#(
    parameter int STAGES     = 2,
    parameter int MODULO     = 16,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    ttl_updown_counter_chain_if.slave bus
);

    if (!modulo_legal(MODULO)) begin : g_bad_modulo
        $error("ttl_updown_counter_chain: MODULO must be in 2..16");
    end

    logic                      count_en;
    logic [STAGES-1:0]         step_en;
    logic [STAGES-1:0]         tc;
    logic [STAGE_W-1:0]        stage_q [STAGES];
    logic [STAGE_W*STAGES-1:0] q_int;
    logic                      rco_int;

    // Every stage moves only when the whole chain is counting
    assign count_en = bus.Clear_bar & bus.Load_bar & bus.ENP & bus.ENT;

    // Carry-enable chain: a stage steps only when all lower stages are terminal
    always_comb begin
        step_en    = '0;
        step_en[0] = count_en;
        for (int i = 1; i < STAGES; i++) begin
            step_en[i] = step_en[i-1] & tc[i-1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        ttl_counter_stage #(
            .MODULO (MODULO)
        ) u_stage (
            .Clk     (Clk),
            .Reset   (Reset),
            .clear   (~bus.Clear_bar),
            .load    (~bus.Load_bar),
            .step_en (step_en[i]),
            .dir     (bus.Up_Dn),
            .d       (bus.D[STAGE_W*i +: STAGE_W]),
            .q       (stage_q[i]),
            .tc      (tc[i])
        );
    end

    // Pack the stage nibbles into the flat counter value
    always_comb begin
        q_int = '0;
        for (int i = 0; i < STAGES; i++) begin
            q_int[STAGE_W*i +: STAGE_W] = stage_q[i];
        end
    end

    assign rco_int      = bus.ENT & (&tc);
    assign bus.Stage_TC = tc;

    // Package-pin delays only on the visible outputs
    assign #(DELAY_RISE, DELAY_FALL) bus.Q   = q_int;
    assign #(DELAY_RISE, DELAY_FALL) bus.RCO = rco_int;

endmodule
